duty_setpoint_ctrl: RTL and testbench
=====================================

Name: duty_setpoint_ctrl

Overview:
Setpoint controller that sits in front of the 8-bit PWM generator and owns its duty_cycle input. It arbitrates between quadrature-encoder step requests and a host load port, and slew-limits the duty value toward the target. Duty changes are applied to the PWM generator only at PWM period boundaries, so the output never glitches.

Parameters:
DUTY_INIT, 127, reset value of target, ramp value and duty_cycle (50%)
SLEW_DIV, 16, clk cycles per ±1 ramp step (legal range 1..65535)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
encoder_a  input  1  encoder channel A (Hall sensor 1), asynchronous to clk
encoder_b  input  1  encoder channel B (Hall sensor 2), asynchronous to clk
period_start  input  1  one-cycle pulse from the PWM generator when its counter wraps 255->0
host_valid  input  1  host load request
host_duty  input  8  host target duty
host_ready  output  1  host load accepted this cycle when host_valid && host_ready
err_clr  input  1  clears enc_error
duty_cycle  output  8  duty value driven to the PWM generator
target  output  8  current target setpoint
busy  output  1  high while duty_cycle != target
enc_error  output  1  sticky flag for an illegal encoder transition

Behaviour:
- Reset (asynchronous): target, ramp_val and duty_cycle = DUTY_INIT. Sync flops and prev AB = 00. Prescaler = 0. enc_error = 0. FSM = IDLE, so host_ready = 1 and busy = 0.
- Input sync: encoder_a and encoder_b each pass through a 2-flop synchronizer. The decoder sees a pin change 2 cycles later and registers a step on the 3rd clk edge.
- Decode compares synced {A,B} against prev {A,B} every cycle:
  - 01->11 (A rises, B=1): +1 request.
  - 00->10 (A rises, B=0): -1 request.
  - Other single-bit changes and no change: no request.
  - Double-bit change (00<->11, 01<->10): no request, enc_error <= 1.
- enc_error is sticky until err_clr. If err_clr and a new illegal transition occur in the same cycle, set wins.
- Target update priority:
  1. host_valid && host_ready: target <= host_duty. An encoder request in the same cycle is dropped.
  2. Otherwise, an encoder request adjusts target by ±1, saturating at 0 and 255. No wrap; at the limit the request is dropped.
- Encoder requests are accepted in every FSM state and may retarget a ramp already in progress.
- ramp_val is the internal next-duty register. duty_cycle <= ramp_val only on cycles where period_start = 1.
- FSM states:
  - IDLE: duty_cycle == target and ramp_val == target. host_ready = 1. Goes to RAMP when target changes; prescaler is cleared on entry.
  - RAMP: prescaler counts 0..SLEW_DIV-1. On the terminal count, ramp_val moves 1 toward target and the prescaler returns to 0. Goes to SETTLE when ramp_val == target.
  - SETTLE: waits for period_start, then goes to IDLE. If target changes meanwhile, goes back to RAMP.
- host_ready = 1 only in IDLE. Loads cannot be accepted while a ramp is in flight.
- If period_start coincides with a ramp step, duty_cycle takes the pre-step ramp_val and the new value lands at the next period.
- busy = (duty_cycle != target), registered-output compatible. Deasserts in the cycle after the final period_start apply.
- Reset asserted mid-ramp: all state returns to reset values immediately. No pending value is applied after reset release.
- Worst-case latency from a target change of N counts to duty_cycle == target: N*SLEW_DIV cycles plus up to one PWM period (256 cycles).

Test Plan:
- Reset: assert rst with SLEW_DIV=4 -> duty_cycle=127, target=127, host_ready=1, busy=0, enc_error=0 while rst is high and after release.
- CW step: AB 00->01->11->10->00 (each held 10 cycles) -> target=128 three cycles after the 01->11 edge; duty_cycle=128 at the first period_start after ramp_val reaches 128; busy falls next cycle.
- Host load: host_duty=131, host_valid for 1 cycle, SLEW_DIV=4, period_start every 256 cycles -> host_ready low from the next cycle; ramp_val steps 128..131 every 4 cycles; duty_cycle jumps to 131 at the next period_start; host_ready returns to 1.
- Saturation: host load 255, then 3 CW steps -> target stays 255; host load 0, then 2 CCW steps -> target stays 0; no wrap at either end.
- Simultaneous/illegal: host_valid with an encoder +1 in the same cycle -> target = host_duty exactly. AB 00->11 in one sample -> enc_error=1 and target unchanged; err_clr -> enc_error=0.
- Reset mid-ramp: host load 200 from 127, assert rst after 40 cycles -> duty_cycle, target and ramp_val all return to 127 asynchronously; no further change after release.

Source files
------------

// File: rtl/duty_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : duty_setpoint_ctrl
// Description : Setpoint controller in front of an 8-bit PWM generator.
//               Arbitrates quadrature-encoder steps against a host load
//               port, slew-limits an internal ramp toward the target and
//               hands the ramp value to the PWM only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module duty_setpoint_ctrl #(
  parameter logic [7:0]  DUTY_INIT = 8'd127,
  parameter int unsigned SLEW_DIV  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       encoder_a,
  input  logic       encoder_b,
  input  logic       period_start,
  input  logic       host_valid,
  input  logic [7:0] host_duty,
  output logic       host_ready,
  input  logic       err_clr,
  output logic [7:0] duty_cycle,
  output logic [7:0] target,
  output logic       busy,
  output logic       enc_error
);

  localparam logic [15:0] c_PRESC_TERM = 16'(SLEW_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RAMP   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  logic       r_a_meta;
  logic       r_a_sync;
  logic       r_b_meta;
  logic       r_b_sync;
  logic [1:0] r_prev_ab;
  state_t     r_state;
  logic [7:0] r_ramp_val;
  logic [15:0] r_presc;

  logic [1:0] w_cur_ab;
  logic [1:0] w_ab_diff;
  logic       w_enc_inc;
  logic       w_enc_dec;
  logic       w_enc_illegal;
  logic       w_host_load;
  logic [7:0] w_target_nxt;
  logic [7:0] w_duty_nxt;
  logic       w_target_chg;
  logic       w_presc_term;

  // Two-flop synchronizers on the encoder pins plus the previous-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_meta  <= 1'b0;
      r_a_sync  <= 1'b0;
      r_b_meta  <= 1'b0;
      r_b_sync  <= 1'b0;
      r_prev_ab <= 2'b00;
    end else begin
      r_a_meta  <= encoder_a;
      r_a_sync  <= r_a_meta;
      r_b_meta  <= encoder_b;
      r_b_sync  <= r_b_meta;
      r_prev_ab <= {r_a_sync, r_b_sync};
    end
  end

  // Step decode: only the A-rising edges count, one request per full cycle
  assign w_cur_ab      = {r_a_sync, r_b_sync};
  assign w_ab_diff     = w_cur_ab ^ r_prev_ab;
  assign w_enc_inc     = (r_prev_ab == 2'b01) && (w_cur_ab == 2'b11);
  assign w_enc_dec     = (r_prev_ab == 2'b00) && (w_cur_ab == 2'b10);
  assign w_enc_illegal = (w_ab_diff == 2'b11);

  // Sticky illegal-transition flag; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_error <= 1'b0;
    end else if (w_enc_illegal) begin
      enc_error <= 1'b1;
    end else if (err_clr) begin
      enc_error <= 1'b0;
    end
  end

  // Host load has priority; encoder steps saturate instead of wrapping
  assign w_host_load = host_valid && host_ready;

  always_comb begin
    w_target_nxt = target;
    if (w_host_load) begin
      w_target_nxt = host_duty;
    end else if (w_enc_inc && (target != 8'hFF)) begin
      w_target_nxt = target + 8'd1;
    end else if (w_enc_dec && (target != 8'h00)) begin
      w_target_nxt = target - 8'd1;
    end
  end

  assign w_target_chg = (w_target_nxt != target);
  assign w_presc_term = (r_presc == c_PRESC_TERM);
  // The PWM sees the pre-step ramp value when a step and a boundary coincide
  assign w_duty_nxt   = period_start ? r_ramp_val : duty_cycle;

  // Ramp FSM with target, ramp, duty and handshake outputs all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      target     <= DUTY_INIT;
      r_ramp_val <= DUTY_INIT;
      duty_cycle <= DUTY_INIT;
      r_presc    <= 16'd0;
      host_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      target     <= w_target_nxt;
      duty_cycle <= w_duty_nxt;
      busy       <= (w_duty_nxt != w_target_nxt);
      case (r_state)
        S_IDLE: begin
          if (w_target_chg) begin
            r_state    <= S_RAMP;
            r_presc    <= 16'd0;
            host_ready <= 1'b0;
          end
        end
        S_RAMP: begin
          if ((r_ramp_val == target) && !w_target_chg) begin
            // A boundary in this very cycle already delivers the final value
            if (period_start) begin
              r_state    <= S_IDLE;
              host_ready <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
            end
          end else if (w_presc_term) begin
            r_presc <= 16'd0;
            if (r_ramp_val < target) begin
              r_ramp_val <= r_ramp_val + 8'd1;
            end else if (r_ramp_val > target) begin
              r_ramp_val <= r_ramp_val - 8'd1;
            end
          end else begin
            r_presc <= r_presc + 16'd1;
          end
        end
        S_SETTLE: begin
          if (w_target_chg) begin
            r_state <= S_RAMP;
            r_presc <= 16'd0;
          end else if (period_start) begin
            r_state    <= S_IDLE;
            host_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          host_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_duty_setpoint_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_setpoint_ctrl
// Description : Scoreboard bench for duty_setpoint_ctrl. Stimulus pushes the
//               expected target sequence; a monitor pops it on every target
//               update and checks that duty only moves at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_setpoint_ctrl;

  localparam int c_SLEW = 4;
  localparam int c_IDLE_BUDGET = 255 * c_SLEW + 256 + 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       encoder_a;
  logic       encoder_b;
  logic       period_start;
  logic       host_valid;
  logic [7:0] host_duty;
  logic       host_ready;
  logic       err_clr;
  logic [7:0] duty_cycle;
  logic [7:0] target;
  logic       busy;
  logic       enc_error;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         model_tgt;

  duty_setpoint_ctrl #(
    .DUTY_INIT (8'd127),
    .SLEW_DIV  (c_SLEW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .encoder_a    (encoder_a),
    .encoder_b    (encoder_b),
    .period_start (period_start),
    .host_valid   (host_valid),
    .host_duty    (host_duty),
    .host_ready   (host_ready),
    .err_clr      (err_clr),
    .duty_cycle   (duty_cycle),
    .target       (target),
    .busy         (busy),
    .enc_error    (enc_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Advance n clock edges, leaving time just past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] v, input int hold);
    encoder_a = v[1];
    encoder_b = v[0];
    tick(hold);
  endtask

  // One full clockwise cycle: +1 expected at 01->11
  task automatic enc_cw();
    set_ab(2'b01, 10);
    if (model_tgt < 255) begin
      model_tgt++;
      exp_q.push_back(8'(model_tgt));
    end
    set_ab(2'b11, 10);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
  endtask

  // One full counter-clockwise cycle: -1 expected at 00->10
  task automatic enc_ccw();
    if (model_tgt > 0) begin
      model_tgt--;
      exp_q.push_back(8'(model_tgt));
    end
    set_ab(2'b10, 10);
    set_ab(2'b11, 10);
    set_ab(2'b01, 10);
    set_ab(2'b00, 10);
  endtask

  task automatic enc_rand();
    if ($urandom_range(0, 1) == 1) enc_cw();
    else enc_ccw();
  endtask

  task automatic host_load(input logic [7:0] v);
    check("host_ready_before_load", int'(host_ready), 1);
    host_valid = 1'b1;
    host_duty  = v;
    if (int'(v) != model_tgt) begin
      model_tgt = int'(v);
      exp_q.push_back(v);
    end
    tick(1);
    host_valid = 1'b0;
  endtask

  // Bounded wait for the ramp to finish, then confirm the settled state
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(host_ready && !busy) && (n < c_IDLE_BUDGET)) begin
      tick(1);
      n++;
    end
    n_cmp++;
    if (n >= c_IDLE_BUDGET) begin
      n_bad++;
      $display("FAIL %s_timeout: waited %0d cycles, required under %0d", name, n, c_IDLE_BUDGET);
    end
    check({name, "_duty"}, int'(duty_cycle), model_tgt);
    check({name, "_target"}, int'(target), model_tgt);
  endtask

  // PWM period pulse: one cycle high every 256 clocks
  initial begin : p_period
    int pcnt;
    pcnt = 0;
    period_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pcnt = (pcnt + 1) % 256;
      period_start = (pcnt == 0);
    end
  end

  // Monitor: pop an expected target on each update, police duty timing
  initial begin : p_monitor
    logic [7:0] prev_t;
    logic [7:0] prev_d;
    logic [7:0] e;
    logic       prev_ps;
    @(negedge clk);
    prev_t  = target;
    prev_d  = duty_cycle;
    prev_ps = period_start;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (target != prev_t) begin
          if (exp_q.size() == 0) begin
            check("target_unexpected_change", int'(target), int'(prev_t));
          end else begin
            e = exp_q.pop_front();
            check("target_update", int'(target), int'(e));
          end
        end
        if (duty_cycle != prev_d) begin
          check("duty_change_at_boundary", int'(prev_ps), 1);
        end
      end
      prev_t  = target;
      prev_d  = duty_cycle;
      prev_ps = period_start;
    end
  end

  initial begin : p_stim
    logic [7:0] v;
    int         op;
    int         k;
    rst        = 1'b1;
    encoder_a  = 1'b0;
    encoder_b  = 1'b0;
    host_valid = 1'b0;
    host_duty  = 8'd0;
    err_clr    = 1'b0;
    model_tgt  = 127;

    // Reset values during and after reset
    tick(3);
    check("rst_duty", int'(duty_cycle), 127);
    check("rst_target", int'(target), 127);
    check("rst_host_ready", int'(host_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_enc_error", int'(enc_error), 0);
    rst = 1'b0;
    tick(5);
    check("post_rst_duty", int'(duty_cycle), 127);
    check("post_rst_target", int'(target), 127);
    check("post_rst_host_ready", int'(host_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    // Clockwise step with exact decode latency
    set_ab(2'b01, 10);
    encoder_a = 1'b1;
    model_tgt = 128;
    exp_q.push_back(8'd128);
    tick(2);
    check("cw_not_early", int'(target), 127);
    tick(1);
    check("cw_latency", int'(target), 128);
    tick(7);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    wait_idle("cw_settle");

    // Host load 131: handshake drop and ramp cadence
    host_load(8'd131);
    check("host_ready_low", int'(host_ready), 0);
    check("ramp_start", int'(dut.r_ramp_val), 128);
    tick(4);
    check("ramp_129", int'(dut.r_ramp_val), 129);
    tick(4);
    check("ramp_130", int'(dut.r_ramp_val), 130);
    tick(4);
    check("ramp_131", int'(dut.r_ramp_val), 131);
    wait_idle("host131_settle");
    check("host_ready_back", int'(host_ready), 1);

    // Saturation at both ends
    host_load(8'd255);
    wait_idle("sat_hi_load");
    repeat (3) enc_cw();
    wait_idle("sat_hi_steps");
    check("sat_hi_target", int'(target), 255);
    host_load(8'd0);
    wait_idle("sat_lo_load");
    repeat (2) enc_ccw();
    wait_idle("sat_lo_steps");
    check("sat_lo_target", int'(target), 0);

    // Host load and encoder +1 landing on the same edge
    host_load(8'd100);
    wait_idle("simul_prep");
    set_ab(2'b01, 10);
    encoder_a = 1'b1;
    tick(2);
    check("simul_host_ready", int'(host_ready), 1);
    v          = 8'(model_tgt ^ 8'h40);
    host_valid = 1'b1;
    host_duty  = v;
    model_tgt  = int'(v);
    exp_q.push_back(v);
    tick(1);
    host_valid = 1'b0;
    check("simul_host_wins", int'(target), int'(v));
    tick(7);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    wait_idle("simul_settle");

    // Illegal double-bit change, set beating a coincident clear
    check("no_error_after_legal", int'(enc_error), 0);
    encoder_a = 1'b1;
    encoder_b = 1'b1;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("illegal_set_wins", int'(enc_error), 1);
    tick(10);
    check("error_sticky", int'(enc_error), 1);
    check("illegal_target_held", int'(target), model_tgt);
    set_ab(2'b10, 10);
    set_ab(2'b00, 10);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_clr", int'(enc_error), 0);

    // Randomized mix of loads, steps and mid-ramp retargets
    for (int it = 0; it < 24; it++) begin
      op = int'($urandom_range(0, 3));
      k  = int'($urandom_range(1, 3));
      case (op)
        0: begin
          host_load(8'($urandom_range(0, 255)));
          wait_idle("rand_load");
        end
        1: begin
          host_load(8'($urandom_range(0, 255)));
          tick(int'($urandom_range(0, 30)));
          repeat (k) enc_rand();
          wait_idle("rand_retarget");
        end
        2: begin
          repeat (k) enc_cw();
          wait_idle("rand_cw");
        end
        default: begin
          repeat (k) enc_ccw();
          wait_idle("rand_ccw");
        end
      endcase
    end

    // Reset in the middle of a ramp toward 200
    host_load(8'd127);
    wait_idle("mid_rst_prep");
    host_load(8'd200);
    tick(39);
    rst = 1'b1;
    #1;
    check("mid_rst_target", int'(target), 127);
    check("mid_rst_duty", int'(duty_cycle), 127);
    check("mid_rst_ramp", int'(dut.r_ramp_val), 127);
    check("mid_rst_host_ready", int'(host_ready), 1);
    exp_q.delete();
    model_tgt = 127;
    tick(3);
    rst = 1'b0;
    tick(300);
    check("after_rst_target", int'(target), 127);
    check("after_rst_duty", int'(duty_cycle), 127);
    check("after_rst_ramp", int'(dut.r_ramp_val), 127);
    check("after_rst_busy", int'(busy), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
